json_uart_tx: RTL and testbench

//  Downstream of the JSON command generator: absorbs its byte burst (one ASCII byte per clk)

---
 rtl/uart_pkg.sv | 9 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/json_uart_tx.sv | 152 +++++++++++++++
 tb/tb_json_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and character constants for the JSON UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [7:0] ASCII_RBRACE = 8'h7D;
   localparam logic [7:0] ASCII_LF     = 8'h0A;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered occupancy count; rdata shows the head entry whenever !empty.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/json_uart_tx.sv
// Buffers a burst of ASCII bytes and serialises them 8N1, LSB first, idle high.
// Optional JSON_NEWLINE_EN: a line feed frame follows every '}' frame.
module json_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        uart_tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             ovf_q;
   logic             baud_last;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_rdata;
`ifdef JSON_NEWLINE_EN
   logic             lf_q, lf_d;
`endif

   byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid),
      .pop   (fifo_pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready  = !fifo_full;
   assign overflow  = ovf_q;
   assign uart_tx   = tx_q;
   assign tx_busy   = (state_q != IDLE);
   assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + CNT_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
`ifdef JSON_NEWLINE_EN
      lf_d     = lf_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = START;
`ifdef JSON_NEWLINE_EN
               lf_d     = (fifo_rdata == ASCII_RBRACE);
`endif
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            // Next frame starts straight after the stop bit: no idle gap between frames.
            if (baud_last) begin
               baud_d = '0;
               bit_d  = '0;
`ifdef JSON_NEWLINE_EN
               if (lf_q) begin
                  shift_d = ASCII_LF;
                  lf_d    = 1'b0;
                  state_d = START;
               end else
`endif
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = START;
`ifdef JSON_NEWLINE_EN
                  lf_d     = (fifo_rdata == ASCII_RBRACE);
`endif
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef JSON_NEWLINE_EN
         lf_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_q | (in_valid & fifo_full);
`ifdef JSON_NEWLINE_EN
         lf_q    <= lf_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

endmodule

// File: tb/tb_json_uart_tx.sv
// Scoreboard bench for json_uart_tx at CLKS_PER_BIT = 10; a line monitor decodes each frame.
module tb_json_uart_tx;

   localparam int CLK_FREQ   = 1000;
   localparam int BAUD       = 100;
   localparam int FIFO_DEPTH = 32;
   localparam int CPB        = CLK_FREQ / BAUD;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready, uart_tx, tx_busy, overflow;
   logic [CW-1:0] fifo_count;

   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   bit         mon_en = 1'b0;
   bit         burst_first = 1'b1;
   int         last_start = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   json_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_q.push_back(b);
`ifdef JSON_NEWLINE_EN
      if (b == 8'h7D) exp_q.push_back(8'h0A);
`endif
   endtask

   // Byte is sampled by the DUT on the next rising edge; returns 1 time unit after it.
   task automatic drive(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      burst_first = 1'b1;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_in_time", 32'(n < max_cyc), 32'd1);
      check("drain_fifo_empty", 32'(fifo_count), 32'd0);
   endtask

   // Line monitor: start detected on first low negedge, bits sampled mid-bit.
   initial begin
      logic [7:0] b;
      int         st;
      forever begin
         @(negedge clk);
         if (mon_en && uart_tx === 1'b0) begin
            st = cyc;
            if (!burst_first) check("frame_gap", 32'(st - last_start), 32'(10 * CPB));
            burst_first = 1'b0;
            last_start  = st;
            repeat (CPB / 2) @(negedge clk);
            check("start_bit", 32'(uart_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", 32'(uart_tx), 32'd1);
            if (exp_q.size() == 0) check("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
            else                   check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
            repeat (CPB / 2 - 1) @(negedge clk);
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string      cmd;
      logic [7:0] t1;
      logic       e;
      int         bad;

      // Reset state
      do_reset();
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // Test 1: single byte, cycle-exact line waveform
      mon_en = 1'b1;
      t1 = 8'h7B;
      push_exp(t1);
      drive(t1);
      for (int k = 0; k < 106; k++) begin
         @(negedge clk);
         if (k < 2)       e = 1'b1;
         else if (k < 12) e = 1'b0;
         else if (k < 92) e = t1[(k - 12) / 10];
         else             e = 1'b1;
         check("t1_line", 32'(uart_tx), 32'(e));
         check("t1_busy", 32'(tx_busy), 32'(k >= 1 && k <= 100));
         if (k == 0) check("t1_count_push", 32'(fifo_count), 32'd1);
         if (k == 1) check("t1_count_pop", 32'(fifo_count), 32'd0);
      end
      wait_drain(300);

      // Test 2: 27-byte command burst, frames back to back
      do_reset();
      cmd = "{\"cmd\":\"mv\",\"x\":12,\"y\":-37}";
      for (int i = 0; i < cmd.len(); i++) begin
         check("t2_in_ready", 32'(in_ready), 32'd1);
         push_exp(cmd[i]);
         drive(cmd[i]);
      end
      check("t2_overflow", 32'(overflow), 32'd0);
      wait_drain(4000);
      check("t2_overflow_end", 32'(overflow), 32'd0);

      // Test 3 + 6: 40-byte burst into 32-entry FIFO, then offer a byte on a pop cycle while full
      do_reset();
      for (int i = 0; i < 40; i++) begin
         check("t3_in_ready", 32'(in_ready), 32'(i <= 32));
         if (i == 33) check("t3_overflow_before", 32'(overflow), 32'd0);
         if (i <= 32) push_exp(8'(8'h30 + i));
         drive(8'(8'h30 + i));
         if (i == 33) check("t3_overflow_set", 32'(overflow), 32'd1);
      end
      check("t3_count_full", 32'(fifo_count), 32'(FIFO_DEPTH));
      repeat (61) @(posedge clk);
      #1;
      check("t6_in_ready_full", 32'(in_ready), 32'd0);
      drive(8'hEE);
      check("t6_count_after_pop", 32'(fifo_count), 32'(FIFO_DEPTH - 1));
      check("t6_overflow", 32'(overflow), 32'd1);
      wait_drain(5000);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);

      // Test 4: reset during DATA bit 3
      mon_en = 1'b0;
      do_reset();
      exp_q.delete();
      drive(8'h55);
      drive(8'hAA);
      drive(8'h33);
      repeat (42) @(posedge clk);
      #1;
      check("t4_bit3_low", 32'(uart_tx), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t4_line_high", 32'(uart_tx), 32'd1);
      check("t4_count", 32'(fifo_count), 32'd0);
      check("t4_busy", 32'(tx_busy), 32'd0);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("t4_quiet_after", 32'(bad), 32'd0);

      // Test 5: '}' followed by 'A' (LF inserted only when configured)
      do_reset();
      mon_en = 1'b1;
      push_exp(8'h7D);
      push_exp(8'h41);
      drive(8'h7D);
      drive(8'h41);
      wait_drain(600);
      check("t5_overflow", 32'(overflow), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
